// File: rtl/mine_placer.sv
// rtl/mine_placer.sv - LFSR-driven mine placement for the 5x5 minesweeper board
//
// On an accepted start, clears the board and draws candidate cells from the low
// five bits of a free-running 16-bit Galois LFSR. It keeps drawing until
// NUM_MINES distinct cells are set. Cells >= 25, already-mined cells and the
// captured safe cell are rejected.
//
// Ports:
//   i_clka        - system clock, state updates on the falling edge
//   i_restart     - asynchronous active-high reset
//   i_start       - request a new board (honoured in IDLE and DONE)
//   i_safe_cell   - cell kept mine-free (>= 25 means none), captured with start
//   i_seed_load   - load i_seed_in into the LFSR on this edge
//   i_seed_in     - new seed; zero is replaced by SEED
//   o_mines       - mine mask, bit i = cell i (row-major)
//   o_mine_count  - mines placed so far on the current board
//   o_busy        - placement in progress
//   o_place_done  - o_mines complete and stable

module mine_placer #(
    parameter int          NUM_MINES = 3,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic        i_clka,
    input  logic        i_restart,
    input  logic        i_start,
    input  logic [4:0]  i_safe_cell,
    input  logic        i_seed_load,
    input  logic [15:0] i_seed_in,
    output logic [24:0] o_mines,
    output logic [4:0]  o_mine_count,
    output logic        o_busy,
    output logic        o_place_done
);

    localparam logic [4:0]  LP_NUM  = 5'(NUM_MINES);
    localparam logic [15:0] LP_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_lfsr;
    logic [24:0] r_mines;
    logic [4:0]  r_mine_count;
    logic [4:0]  r_safe;
    logic        r_busy;
    logic        r_place_done;

    logic [15:0] w_lfsr_step;
    logic [15:0] w_lfsr_next;
    logic [4:0]  w_cand;
    logic [24:0] w_cand_onehot;
    logic        w_start_ok;
    logic        w_accept;
    logic        w_last;
    logic [4:0]  w_count_inc;
    logic        w_busy_next;
    logic        w_done_next;

    // Right-shifting Galois step; the LFSR runs on every edge so user timing
    // feeds the randomness.
    assign w_lfsr_step = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LP_TAPS : 16'h0000);
    assign w_lfsr_next = i_seed_load ? ((i_seed_in == 16'h0000) ? SEED : i_seed_in)
                                     : w_lfsr_step;

    // Candidate is the LFSR value before this edge's advance.
    assign w_cand        = r_lfsr[4:0];
    // Shifts past bit 24 fall off, and those candidates are rejected anyway.
    assign w_cand_onehot = 25'd1 << w_cand;
    assign w_start_ok    = i_start && (r_state != ST_DRAW);
    assign w_accept      = (r_state == ST_DRAW)
                        && (w_cand < 5'd25)
                        && ((w_cand_onehot & r_mines) == 25'd0)
                        && (w_cand != r_safe);
    assign w_count_inc   = r_mine_count + 5'd1;
    assign w_last        = w_accept && (w_count_inc == LP_NUM);

    // State register
    always_ff @(negedge i_clka or posedge i_restart) begin
        if (i_restart) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_state_next = ST_DRAW;
            ST_DRAW: if (w_last)  w_state_next = ST_DONE;
            ST_DONE: if (i_start) w_state_next = ST_DRAW;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output decode from the next state, registered below so status flags
    // change on the same edge as the mask.
    always_comb begin
        w_busy_next = 1'b0;
        w_done_next = 1'b0;
        case (w_state_next)
            ST_DRAW: w_busy_next = 1'b1;
            ST_DONE: w_done_next = 1'b1;
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(negedge i_clka or posedge i_restart) begin
        if (i_restart) begin
            r_lfsr       <= SEED;
            r_mines      <= 25'd0;
            r_mine_count <= 5'd0;
            r_safe       <= 5'd31;
            r_busy       <= 1'b0;
            r_place_done <= 1'b0;
        end else begin
            r_lfsr       <= w_lfsr_next;
            r_busy       <= w_busy_next;
            r_place_done <= w_done_next;
            if (w_start_ok) begin
                r_mines      <= 25'd0;
                r_mine_count <= 5'd0;
                r_safe       <= i_safe_cell;
            end else if (w_accept) begin
                r_mines      <= r_mines | w_cand_onehot;
                r_mine_count <= w_count_inc;
            end
        end
    end

    assign o_mines      = r_mines;
    assign o_mine_count = r_mine_count;
    assign o_busy       = r_busy;
    assign o_place_done = r_place_done;

endmodule

// File: tb/tb_mine_placer.sv
// tb/tb_mine_placer.sv - self-checking bench for mine_placer

module tb_mine_placer;

    localparam int BOUND = 20000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        restart;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        start_a, start_b;
    logic [4:0]  safe_a, safe_b;
    logic [24:0] mines_a, mines_b;
    logic [4:0]  cnt_a, cnt_b;
    logic        busy_a, busy_b, done_a, done_b;

    int checks = 0;
    int errors = 0;
    int sel = 0;

    logic [24:0] mines_s;
    logic [4:0]  cnt_s;
    logic        busy_s, done_s;
    assign mines_s = (sel == 1) ? mines_b : mines_a;
    assign cnt_s   = (sel == 1) ? cnt_b   : cnt_a;
    assign busy_s  = (sel == 1) ? busy_b  : busy_a;
    assign done_s  = (sel == 1) ? done_b  : done_a;

    mine_placer #(.NUM_MINES(3), .SEED(16'hACE1)) dut_a (
        .i_clka(clk), .i_restart(restart), .i_start(start_a), .i_safe_cell(safe_a),
        .i_seed_load(seed_load), .i_seed_in(seed_in), .o_mines(mines_a),
        .o_mine_count(cnt_a), .o_busy(busy_a), .o_place_done(done_a));

    mine_placer #(.NUM_MINES(24), .SEED(16'hACE1)) dut_b (
        .i_clka(clk), .i_restart(restart), .i_start(start_b), .i_safe_cell(safe_b),
        .i_seed_load(seed_load), .i_seed_in(seed_in), .o_mines(mines_b),
        .o_mine_count(cnt_b), .o_busy(busy_b), .o_place_done(done_b));

    // Reference LFSR: polynomial x^16+x^14+x^13+x^11+1, Galois right shift.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic logic [15:0] seed_eff(input logic [15:0] s);
        return (s == 16'h0000) ? 16'hACE1 : s;
    endfunction

    logic [15:0] m_lfsr;
    always @(negedge clk or posedge restart) begin
        if (restart)        m_lfsr <= 16'hACE1;
        else if (seed_load) m_lfsr <= seed_eff(seed_in);
        else                m_lfsr <= lfsr_step(m_lfsr);
    end

    // Board outcome from the LFSR state just after the start edge.
    task automatic predict(input logic [15:0] l0, input int safe, input int n,
                           output logic [24:0] mask, output int lat);
        bit          taken[25];
        int          placed;
        int          c;
        logic [15:0] l;
        foreach (taken[i]) taken[i] = 1'b0;
        placed = 0;
        lat    = 0;
        l      = l0;
        while (placed < n && lat < 200000) begin
            c = int'(l[4:0]);
            if (c < 25 && !taken[c] && c != safe) begin
                taken[c] = 1'b1;
                placed++;
            end
            l = lfsr_step(l);
            lat++;
        end
        mask = '0;
        for (int i = 0; i < 25; i++) mask[i] = taken[i];
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_start(input int which, input logic v);
        if (which == 1) start_b = v;
        else            start_a = v;
    endtask

    // Entered just after a rising edge; returns just after a rising edge.
    task automatic run_board(input int which, input int safe, input bit do_seed,
                             input logic [15:0] seed, input int poke_at,
                             output logic [24:0] got_mask, output int got_lat);
        logic [24:0] exp_mask;
        logic [24:0] prev;
        logic [4:0]  prevc;
        int          exp_lat;
        int          n;
        int          k;
        bit          bad;
        n   = (which == 1) ? 24 : 3;
        sel = which;
        drive_start(which, 1'b1);
        if (which == 1) safe_b = 5'(safe);
        else            safe_a = 5'(safe);
        seed_load = do_seed;
        seed_in   = seed;
        @(posedge clk);
        drive_start(which, 1'b0);
        seed_load = 1'b0;
        predict(m_lfsr, safe, n, exp_mask, exp_lat);
        chk("start_busy", 32'(busy_s), 32'd1);
        chk("start_done_low", 32'(done_s), 32'd0);
        chk("start_mines_clear", 32'(mines_s), 32'd0);
        chk("start_count_clear", 32'(cnt_s), 32'd0);
        k = 0; bad = 1'b0; prev = '0; prevc = '0;
        while (done_s !== 1'b1 && k < BOUND) begin
            if (k == poke_at) drive_start(which, 1'b1);
            @(posedge clk);
            drive_start(which, 1'b0);
            k++;
            if ((mines_s & prev) !== prev || cnt_s < prevc ||
                $countones(mines_s) != int'(cnt_s)) bad = 1'b1;
            if (done_s !== 1'b1 && busy_s !== 1'b1) bad = 1'b1;
            prev  = mines_s;
            prevc = cnt_s;
        end
        chk("board_completes", 32'(done_s), 32'd1);
        chk("board_latency", 32'(k), 32'(exp_lat));
        chk("board_mask", 32'(mines_s), 32'(exp_mask));
        chk("board_count", 32'(cnt_s), 32'(n));
        chk("board_busy_low", 32'(busy_s), 32'd0);
        chk("draw_invariants", 32'(bad), 32'd0);
        if (safe < 25) chk("safe_bit_clear", 32'(mines_s[safe]), 32'd0);
        got_mask = mines_s;
        got_lat  = k;
    endtask

    typedef struct {
        logic [15:0] seed;
        int          safe;
        logic [24:0] exp_mask;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [24:0] gm;
        int          gl;
        int          k;
        bit          bad;
        logic [24:0] held;

        vecs[0].seed = 16'h1234; vecs[0].safe = 31;
        vecs[1].seed = 16'h1234; vecs[1].safe = 31;
        vecs[2].seed = 16'h0000; vecs[2].safe = 12;
        vecs[3].seed = 16'hACE1; vecs[3].safe = 12;
        vecs[4].seed = 16'hBEEF; vecs[4].safe = 0;
        vecs[5].seed = 16'h0001; vecs[5].safe = 24;
        vecs[6].seed = 16'hFFFF; vecs[6].safe = 25;
        foreach (vecs[i]) predict(seed_eff(vecs[i].seed), vecs[i].safe, 3,
                                  vecs[i].exp_mask, vecs[i].exp_lat);

        restart = 1'b1; seed_load = 1'b0; seed_in = '0;
        start_a = 1'b0; start_b = 1'b0; safe_a = '0; safe_b = '0;
        repeat (2) @(posedge clk);
        chk("rst_mines_a", 32'(mines_a), 32'd0);
        chk("rst_count_a", 32'(cnt_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_done_a", 32'(done_a), 32'd0);
        chk("rst_mines_b", 32'(mines_b), 32'd0);
        restart = 1'b0;
        @(posedge clk);

        // Basic board from the free-running LFSR, no exclusion.
        run_board(0, 31, 1'b0, 16'h0, -1, gm, gl);

        // Seeded boards, back to back so each start re-arms from DONE.
        for (int i = 0; i < 7; i++) begin
            run_board(0, vecs[i].safe, 1'b1, vecs[i].seed, -1, gm, gl);
            chk("vec_mask", 32'(gm), 32'(vecs[i].exp_mask));
            chk("vec_latency", 32'(gl), 32'(vecs[i].exp_lat));
        end

        // Random gaps, stray seed loads, random safe cells.
        for (int b = 0; b < 25; b++) begin
            int gap;
            gap = $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 3) == 0) begin
                    seed_load = 1'b1;
                    seed_in   = 16'($urandom);
                end
                @(posedge clk);
                seed_load = 1'b0;
            end
            run_board(0, $urandom_range(0, 31), ($urandom_range(0, 3) == 0),
                      16'($urandom), -1, gm, gl);
        end

        // Start pulsed mid-DRAW must be ignored; result must still hold afterwards.
        run_board(1, 31, 1'b0, 16'h0, 3, gm, gl);
        held = mines_b;
        bad  = 1'b0;
        repeat (20) begin
            @(posedge clk);
            if (done_b !== 1'b1 || mines_b !== held) bad = 1'b1;
        end
        chk("done_holds", 32'(bad), 32'd0);

        // Asynchronous reset in the middle of a draw.
        sel = 1;
        start_b = 1'b1; safe_b = 5'd31;
        @(posedge clk);
        start_b = 1'b0;
        k = 0;
        while (cnt_b < 5'd2 && k < BOUND) begin
            @(posedge clk);
            k++;
        end
        chk("partial_draw", 32'(busy_b && cnt_b >= 5'd2), 32'd1);
        #3 restart = 1'b1;
        #1;
        chk("async_rst_mines", 32'(mines_b), 32'd0);
        chk("async_rst_count", 32'(cnt_b), 32'd0);
        chk("async_rst_busy", 32'(busy_b), 32'd0);
        chk("async_rst_done", 32'(done_b), 32'd0);
        chk("async_rst_done_a", 32'(done_a), 32'd0);
        #2 restart = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            @(posedge clk);
            if (busy_b !== 1'b0 || done_b !== 1'b0 || mines_b !== '0 || cnt_b !== '0) bad = 1'b1;
        end
        chk("idle_after_reset", 32'(bad), 32'd0);

        // All-but-safe boards.
        for (int b = 0; b < 200; b++) begin
            run_board(1, 12, 1'b0, 16'h0, -1, gm, gl);
            chk("full_board_mask", 32'(gm), 32'h1FFEFFF);
            if ($urandom_range(0, 1) == 1) @(posedge clk);
            if (errors > 20) break;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
